// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with parallel load, single-step and counted bursts
// Optional registered parity output enabled by defining USR_PARITY_EN.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
`ifdef USR_PARITY_EN
  output logic             parity,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_mode;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last_step;

  // A burst always uses the mode latched at start; idle single steps use the live mode.
  assign w_op        = r_busy ? r_mode : mode;
  assign w_last_step = (r_cnt == CNT_W'(1));

  always_comb begin
    w_shifted = r_q;
    case (w_op)
      3'b001:  w_shifted = {r_q[WIDTH-2:0], sin_r};
      3'b010:  w_shifted = {sin_l, r_q[WIDTH-1:1]};
      3'b011:  w_shifted = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      3'b100:  w_shifted = {r_q[0], r_q[WIDTH-1:1]};
      3'b101:  w_shifted = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      default: w_shifted = r_q;
    endcase
  end

  always_comb begin
    w_q_next = r_q;
    if (load)
      w_q_next = din;
    else if (r_busy || (en && !start))
      w_q_next = w_shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_mode <= 3'b000;
    end else begin
      r_q <= w_q_next;
      if (load) begin
        r_busy <= 1'b0;
        r_done <= 1'b0;
        r_cnt  <= '0;
      end else if (r_busy) begin
        r_cnt  <= r_cnt - CNT_W'(1);
        r_busy <= !w_last_step;
        r_done <= w_last_step;
      end else if (start) begin
        r_mode <= mode;
        r_cnt  <= count;
        r_busy <= (count != '0);
        r_done <= (count == '0);
      end else begin
        r_done <= 1'b0;
      end
    end
  end

`ifdef USR_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst)
      r_parity <= 1'b0;
    else
      r_parity <= ^w_q_next;
  end

  assign parity = r_parity;
`endif

  assign q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg: directed plan plus random traffic
// Define USR_PARITY_EN to also check the parity output.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, load, en, sin_r, sin_l, start;
  logic [7:0] din;
  logic [2:0] mode;
  logic [3:0] count;
  logic [7:0] q;
  logic       sout_l, sout_r, busy, done;
`ifdef USR_PARITY_EN
  logic       parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  // Reference state: the register value and how many burst steps remain.
  logic [7:0] m_q    = '0;
  int         m_rem  = 0;
  logic [2:0] m_op   = '0;
  logic       m_done = 1'b0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .count(count),
`ifdef USR_PARITY_EN
    .parity(parity),
`endif
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f_apply(logic [2:0] op, logic [7:0] v, logic sr, logic sl);
    case (op)
      3'd1:    return (v << 1) | 8'(sr);
      3'd2:    return (v >> 1) | (8'(sl) << 7);
      3'd3:    return (v << 1) | (v >> 7);
      3'd4:    return (v >> 1) | (v << 7);
      3'd5:    return 8'($signed(v) >>> 1);
      default: return v;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model over one edge using the inputs now applied, then queue its result.
  task automatic tick();
    exp_t e;
    if (rst) begin
      m_q = '0; m_rem = 0; m_op = '0; m_done = 1'b0;
    end else if (load) begin
      m_q = din; m_rem = 0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_q = f_apply(m_op, m_q, sin_r, sin_l);
      m_rem--;
      m_done = (m_rem == 0);
    end else if (start) begin
      m_op = mode; m_rem = int'(count); m_done = (count == 0);
    end else begin
      if (en) m_q = f_apply(mode, m_q, sin_r, sin_l);
      m_done = 1'b0;
    end
    e.q = m_q; e.busy = (m_rem > 0); e.done = m_done;
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    rst = 0; load = 0; en = 0; start = 0; sin_r = 0; sin_l = 0;
    din = '0; mode = '0; count = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q", q, e.q);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("sout_l", sout_l, e.q[7]);
      chk("sout_r", sout_r, e.q[0]);
`ifdef USR_PARITY_EN
      chk("parity", parity, ^e.q);
`endif
    end
  end

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    chk("reset_q", q, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 0;

    load = 1; din = 8'hA5; tick(); load = 0;
    en = 1; mode = 3'b001; sin_r = 1; tick(); en = 0; sin_r = 0;
    chk("shl_q", q, 8'h4B);

    load = 1; din = 8'h81; tick(); load = 0;
    start = 1; mode = 3'b100; count = 4'd3; tick(); start = 0;
    tick(); chk("ror_1", q, 8'hC0);
    tick(); chk("ror_2", q, 8'h60);
    tick(); chk("ror_3", q, 8'h30);
    chk("ror_done", done, 1);
    tick(); chk("ror_done_end", done, 0);

    load = 1; din = 8'h90; tick(); load = 0;
    start = 1; mode = 3'b101; count = 4'd4; tick();
    mode = 3'b001; count = 4'd9;
    tick(); tick(); start = 0;
    tick(); tick();
    chk("asr_final", q, 8'hF9);
    chk("asr_done", done, 1);
    tick();

    load = 1; din = 8'h01; tick(); load = 0;
    start = 1; mode = 3'b011; count = 4'd5; tick(); start = 0;
    tick(); tick();
    load = 1; din = 8'h3C; tick(); load = 0;
    chk("abort_q", q, 8'h3C);
    chk("abort_busy", busy, 0);
    tick(); chk("abort_nodone", done, 0);

    load = 1; din = 8'h5A; tick(); load = 0;
    start = 1; count = 4'd0; mode = 3'b001; tick(); start = 0;
    chk("cnt0_q", q, 8'h5A);
    chk("cnt0_done", done, 1);
    tick(); chk("cnt0_done_end", done, 0);

    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 19) == 0);
      din   = 8'($urandom);
      en    = $urandom_range(0, 1);
      start = ($urandom_range(0, 5) == 0);
      mode  = 3'($urandom);
      count = 4'($urandom_range(0, 12));
      sin_r = $urandom_range(0, 1);
      sin_l = $urandom_range(0, 1);
      tick();
    end
    idle_inputs();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
